cache_miss_requester: RTL and testbench

- Cache-side initiator of the miss interface to the memory arbiter. One instance sits in each of I$ and D$.
- Accepts one miss at a time from the cache controller. If the victim line is dirty, it first writes it back as a store request, then issues the line fill as a load request.
- Filters shared responses by cache id and returns the fill line, or a bus error, to the cache.
- Request outputs pack into memory_request_t at core_top.

---
 rtl/cache_miss_requester.sv | 227 ++++++++++++++++++++++
 tb/tb_cache_miss_requester.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_requester.sv
// cache_miss_requester: cache-side initiator of the miss interface.
// Takes one miss at a time. A dirty victim is written back first, then the
// line fill is issued. Shared responses are filtered by cache id.
module cache_miss_requester #(
    parameter int CACHE_ID     = 0,
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 128,
    parameter int OFFSET_WIDTH = 4,
    parameter int THR_WIDTH    = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic [THR_WIDTH-1:0]  miss_thread_id,
    input  logic                  evict_valid,
    input  logic [ADDR_WIDTH-1:0] evict_addr,
    input  logic [LINE_WIDTH-1:0] evict_data,
    output logic                  req_valid_miss,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_is_store,
    output logic [LINE_WIDTH-1:0] req_data,
    output logic [THR_WIDTH-1:0]  req_thread_id,
    input  logic                  rsp_valid_miss,
    input  logic                  rsp_cache_id,
    input  logic                  rsp_bus_error,
    input  logic [LINE_WIDTH-1:0] rsp_data_miss,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic [THR_WIDTH-1:0]  fill_thread_id,
    output logic                  fill_bus_error
);

    // state   | meaning
    // IDLE    | ready for a miss
    // WB_REQ  | one-cycle writeback (store) request pulse
    // WB_WAIT | waiting for the writeback response
    // LD_REQ  | one-cycle fill (load) request pulse
    // LD_WAIT | waiting for the fill response
    // FILL    | one-cycle completion pulse to the cache
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        LD_REQ  = 3'd3,
        LD_WAIT = 3'd4,
        FILL    = 3'd5
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [THR_WIDTH-1:0]  thr_q, thr_d;
    logic [ADDR_WIDTH-1:0] evict_addr_q, evict_addr_d;
    logic [LINE_WIDTH-1:0] evict_data_q, evict_data_d;
    logic [CNT_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_is_store_q, req_is_store_d;
    logic [LINE_WIDTH-1:0] req_data_q, req_data_d;
    logic [THR_WIDTH-1:0]  req_thr_q, req_thr_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_WIDTH-1:0] fill_data_q, fill_data_d;
    logic [THR_WIDTH-1:0]  fill_thr_q, fill_thr_d;
    logic                  fill_err_q, fill_err_d;

    logic rsp_match;
    logic tmo_expired;

    function automatic logic [ADDR_WIDTH-1:0] line_idx(input logic [ADDR_WIDTH-1:0] a);
        return a >> OFFSET_WIDTH;
    endfunction

    // Responses for the other cache share the bus and are dropped here.
    assign rsp_match   = rsp_valid_miss && (rsp_cache_id == 1'(CACHE_ID));
    assign tmo_expired = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

    assign miss_ready     = (state_q == IDLE);
    assign req_valid_miss = (state_q == WB_REQ) || (state_q == LD_REQ);
    assign fill_valid     = (state_q == FILL);
    assign req_addr       = req_addr_q;
    assign req_is_store   = req_is_store_q;
    assign req_data       = req_data_q;
    assign req_thread_id  = req_thr_q;
    assign fill_addr      = fill_addr_q;
    assign fill_data      = fill_data_q;
    assign fill_thread_id = fill_thr_q;
    assign fill_bus_error = fill_err_q;

    // Next-state, capture and request/fill field updates.
    always_comb begin
        state_d        = state_q;
        miss_addr_d    = miss_addr_q;
        thr_d          = thr_q;
        evict_addr_d   = evict_addr_q;
        evict_data_d   = evict_data_q;
        tmo_d          = tmo_q;
        req_addr_d     = req_addr_q;
        req_is_store_d = req_is_store_q;
        req_data_d     = req_data_q;
        req_thr_d      = req_thr_q;
        fill_addr_d    = fill_addr_q;
        fill_data_d    = fill_data_q;
        fill_thr_d     = fill_thr_q;
        fill_err_d     = fill_err_q;

        unique case (state_q)
            IDLE: begin
                if (miss_valid) begin
                    miss_addr_d  = miss_addr;
                    thr_d        = miss_thread_id;
                    evict_addr_d = evict_addr;
                    evict_data_d = evict_data;
                    req_thr_d    = miss_thread_id;
                    if (evict_valid) begin
                        state_d        = WB_REQ;
                        req_addr_d     = line_idx(evict_addr);
                        req_is_store_d = 1'b1;
                        req_data_d     = evict_data;
                    end else begin
                        state_d        = LD_REQ;
                        req_addr_d     = line_idx(miss_addr);
                        req_is_store_d = 1'b0;
                        req_data_d     = '0;
                    end
                end
            end
            WB_REQ: begin
                tmo_d   = '0;
                state_d = WB_WAIT;
            end
            WB_WAIT: begin
                // A response in the expiry cycle wins over the timeout.
                if (rsp_match) begin
                    if (rsp_bus_error) begin
                        state_d     = FILL;
                        fill_addr_d = miss_addr_q;
                        fill_thr_d  = thr_q;
                        fill_data_d = '0;
                        fill_err_d  = 1'b1;
                    end else begin
                        state_d        = LD_REQ;
                        req_addr_d     = line_idx(miss_addr_q);
                        req_is_store_d = 1'b0;
                        req_data_d     = '0;
                        req_thr_d      = thr_q;
                    end
                end else if (tmo_expired) begin
                    state_d     = FILL;
                    fill_addr_d = miss_addr_q;
                    fill_thr_d  = thr_q;
                    fill_data_d = '0;
                    fill_err_d  = 1'b1;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            LD_REQ: begin
                tmo_d   = '0;
                state_d = LD_WAIT;
            end
            LD_WAIT: begin
                if (rsp_match) begin
                    state_d     = FILL;
                    fill_addr_d = miss_addr_q;
                    fill_thr_d  = thr_q;
                    fill_data_d = rsp_bus_error ? '0 : rsp_data_miss;
                    fill_err_d  = rsp_bus_error;
                end else if (tmo_expired) begin
                    state_d     = FILL;
                    fill_addr_d = miss_addr_q;
                    fill_thr_d  = thr_q;
                    fill_data_d = '0;
                    fill_err_d  = 1'b1;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            miss_addr_q    <= '0;
            thr_q          <= '0;
            evict_addr_q   <= '0;
            evict_data_q   <= '0;
            tmo_q          <= '0;
            req_addr_q     <= '0;
            req_is_store_q <= 1'b0;
            req_data_q     <= '0;
            req_thr_q      <= '0;
            fill_addr_q    <= '0;
            fill_data_q    <= '0;
            fill_thr_q     <= '0;
            fill_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            miss_addr_q    <= miss_addr_d;
            thr_q          <= thr_d;
            evict_addr_q   <= evict_addr_d;
            evict_data_q   <= evict_data_d;
            tmo_q          <= tmo_d;
            req_addr_q     <= req_addr_d;
            req_is_store_q <= req_is_store_d;
            req_data_q     <= req_data_d;
            req_thr_q      <= req_thr_d;
            fill_addr_q    <= fill_addr_d;
            fill_data_q    <= fill_data_d;
            fill_thr_q     <= fill_thr_d;
            fill_err_q     <= fill_err_d;
        end
    end

endmodule

// File: tb/tb_cache_miss_requester.sv
// Bench for cache_miss_requester (CACHE_ID=1, TIMEOUT=8). Plays the cache and
// the memory arbiter; expected requests and fills come from a transaction-level
// view of each miss.
module tb_cache_miss_requester;

    localparam int AW  = 32;
    localparam int LW  = 128;
    localparam int OW  = 4;
    localparam int TW  = 2;
    localparam int TMO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          miss_valid;
    logic          miss_ready;
    logic [AW-1:0] miss_addr;
    logic [TW-1:0] miss_thread_id;
    logic          evict_valid;
    logic [AW-1:0] evict_addr;
    logic [LW-1:0] evict_data;
    logic          req_valid_miss;
    logic [AW-1:0] req_addr;
    logic          req_is_store;
    logic [LW-1:0] req_data;
    logic [TW-1:0] req_thread_id;
    logic          rsp_valid_miss;
    logic          rsp_cache_id;
    logic          rsp_bus_error;
    logic [LW-1:0] rsp_data_miss;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;
    logic [LW-1:0] fill_data;
    logic [TW-1:0] fill_thread_id;
    logic          fill_bus_error;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] last_fill_addr = '0;
    logic [LW-1:0] last_fill_data = '0;
    logic [TW-1:0] last_fill_tid  = '0;
    logic          last_fill_err  = 1'b0;
    bit            stray_next     = 1'b0;

    cache_miss_requester #(
        .CACHE_ID(1), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
        .OFFSET_WIDTH(OW), .THR_WIDTH(TW), .TIMEOUT(TMO)
    ) dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .miss_thread_id(miss_thread_id),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
        .req_valid_miss(req_valid_miss), .req_addr(req_addr), .req_is_store(req_is_store),
        .req_data(req_data), .req_thread_id(req_thread_id),
        .rsp_valid_miss(rsp_valid_miss), .rsp_cache_id(rsp_cache_id),
        .rsp_bus_error(rsp_bus_error), .rsp_data_miss(rsp_data_miss),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_thread_id(fill_thread_id), .fill_bus_error(fill_bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle_bus();
        rsp_valid_miss = 1'b0;
        rsp_cache_id   = 1'($urandom);
        rsp_bus_error  = 1'($urandom);
        rsp_data_miss  = rand_line();
    endtask

    task automatic chk_reset_vals();
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_req_valid", req_valid_miss, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_req_is_store", req_is_store, 0);
        chk("rst_req_data", req_data, 0);
        chk("rst_req_tid", req_thread_id, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill_addr", fill_addr, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_fill_tid", fill_thread_id, 0);
        chk("rst_fill_err", fill_bus_error, 0);
        last_fill_addr = '0; last_fill_data = '0; last_fill_tid = '0; last_fill_err = 1'b0;
    endtask

    // Called at the negedge of a request-pulse cycle. Acts as memory for the
    // following wait window; lat = WAIT cycle carrying the matched response,
    // 0 = never respond. Returns at the negedge of the cycle after the window.
    task automatic phase(input bit st, input logic [AW-1:0] exp_addr, input logic [LW-1:0] exp_dat,
                         input logic [TW-1:0] tid, input int lat, input bit err, input int fpct,
                         input logic [LW-1:0] rdat, output bit ok);
        int kmax;
        chk("req_pulse", req_valid_miss, 1);
        chk("req_is_store", req_is_store, st);
        chk("req_addr", req_addr, exp_addr);
        chk("req_data", req_data, exp_dat);
        chk("req_tid", req_thread_id, tid);
        chk("fill_early", fill_valid, 0);
        kmax = (lat == 0) ? TMO : lat;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clock);
            chk("req_single_pulse", req_valid_miss, 0);
            chk("req_addr_hold", req_addr, exp_addr);
            chk("fill_during_wait", fill_valid, 0);
            chk("ready_during_wait", miss_ready, 0);
            if (k == lat) begin
                rsp_valid_miss = 1'b1;
                rsp_cache_id   = 1'b1;
                rsp_bus_error  = err;
                rsp_data_miss  = rdat;
            end else begin
                rsp_valid_miss = ($urandom_range(99) < fpct);
                rsp_cache_id   = 1'b0;
                rsp_bus_error  = 1'($urandom);
                rsp_data_miss  = rand_line();
            end
        end
        @(negedge clock);
        idle_bus();
        ok = (lat != 0) && !err;
    endtask

    // One complete miss. hold keeps miss_valid high through the FILL cycle.
    task automatic do_miss(input bit ev, input logic [AW-1:0] ea, input logic [LW-1:0] ed,
                           input logic [AW-1:0] ma, input logic [TW-1:0] tid,
                           input int wb_lat, input bit wb_err, input int ld_lat, input bit ld_err,
                           input int fpct, input bit hold);
        logic [LW-1:0] exp_data, ldd;
        bit exp_err, do_ld, ok, timed_out;
        @(negedge clock);
        chk("idle_ready", miss_ready, 1);
        chk("fill_one_cycle", fill_valid, 0);
        chk("hold_fill_addr", fill_addr, last_fill_addr);
        chk("hold_fill_data", fill_data, last_fill_data);
        chk("hold_fill_tid", fill_thread_id, last_fill_tid);
        chk("hold_fill_err", fill_bus_error, last_fill_err);
        if (stray_next) begin
            rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_bus_error = 1'b0;
            rsp_data_miss = rand_line();
            stray_next = 1'b0;
        end else begin
            idle_bus();
        end
        miss_valid = 1'b1; miss_addr = ma; miss_thread_id = tid;
        evict_valid = ev; evict_addr = ea; evict_data = ed;
        @(negedge clock);
        idle_bus();
        miss_valid = 1'b0;
        miss_addr = $urandom; miss_thread_id = 2'($urandom);
        evict_valid = 1'($urandom); evict_addr = $urandom; evict_data = rand_line();
        exp_err = 1'b0; exp_data = '0; do_ld = 1'b1; timed_out = 1'b0;
        if (ev) begin
            phase(1'b1, ea >> OW, ed, tid, wb_lat, wb_err, fpct, rand_line(), ok);
            if (!ok) begin exp_err = 1'b1; do_ld = 1'b0; timed_out = (wb_lat == 0); end
        end
        if (do_ld) begin
            ldd = rand_line();
            phase(1'b0, ma >> OW, '0, tid, ld_lat, ld_err, fpct, ldd, ok);
            if (ok) exp_data = ldd;
            else begin exp_err = 1'b1; timed_out = (ld_lat == 0); end
        end
        chk("fill_valid", fill_valid, 1);
        chk("fill_ready_low", miss_ready, 0);
        chk("fill_no_req", req_valid_miss, 0);
        chk("fill_addr", fill_addr, ma);
        chk("fill_data", fill_data, exp_data);
        chk("fill_tid", fill_thread_id, tid);
        chk("fill_err", fill_bus_error, exp_err);
        last_fill_addr = ma; last_fill_data = exp_data;
        last_fill_tid = tid; last_fill_err = exp_err;
        if (timed_out) begin
            rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_bus_error = 1'b0;
            rsp_data_miss = rand_line();
            stray_next = 1'b1;
        end
        if (hold) begin
            miss_valid = 1'b1; miss_addr = $urandom; evict_valid = 1'($urandom);
        end
    endtask

    initial begin
        logic [LW-1:0] aa;
        bit ev, we, le, hd;
        int wl, ll;
        aa = {LW/8{8'hAA}};
        reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_thread_id = '0;
        evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
        idle_bus();
        repeat (3) @(negedge clock);
        chk_reset_vals();
        reset = 1'b0;

        // clean fill, latency 3
        do_miss(0, 32'h0, '0, 32'h1040, 2'd2, 0, 0, 3, 0, 0, 0);
        // dirty eviction
        do_miss(1, 32'h3000, aa, 32'h1000, 2'd1, 2, 0, 4, 0, 0, 0);
        // foreign-id responses during the wait windows
        do_miss(0, 32'h0, '0, 32'h2230, 2'd3, 0, 0, 6, 0, 100, 0);
        // bus error on the writeback, then on a load
        do_miss(1, 32'h4010, rand_line(), 32'h5000, 2'd0, 3, 1, 1, 0, 0, 0);
        do_miss(0, 32'h0, '0, 32'h6008, 2'd1, 0, 0, 2, 1, 0, 0);
        // timeout on a load and on a writeback, stray responses afterwards
        do_miss(0, 32'h0, '0, 32'h7000, 2'd2, 0, 0, 0, 0, 0, 0);
        do_miss(1, 32'h8000, rand_line(), 32'h9000, 2'd3, 0, 0, 0, 0, 50, 0);
        // response in the expiry cycle wins
        do_miss(0, 32'h0, '0, 32'hA0F0, 2'd0, 0, 0, TMO, 0, 0, 0);
        // miss held high during FILL, unaligned addresses
        do_miss(1, 32'hB00F, rand_line(), 32'hC007, 2'd1, 1, 0, 1, 0, 0, 1);
        do_miss(0, 32'h0, '0, 32'hD123, 2'd2, 0, 0, 2, 0, 0, 0);

        // reset while in LD_WAIT, then a late response
        @(negedge clock);
        chk("pre_rst_ready", miss_ready, 1);
        idle_bus();
        miss_valid = 1'b1; miss_addr = 32'hE040; miss_thread_id = 2'd3; evict_valid = 1'b0;
        @(negedge clock);
        miss_valid = 1'b0;
        chk("rst_case_pulse", req_valid_miss, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_reset_vals();
        rsp_valid_miss = 1'b1; rsp_cache_id = 1'b1; rsp_bus_error = 1'b0; rsp_data_miss = rand_line();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            idle_bus();
            chk("post_rst_no_fill", fill_valid, 0);
            chk("post_rst_ready", miss_ready, 1);
        end

        // randomized misses
        for (int n = 0; n < 40; n++) begin
            ev = 1'($urandom);
            wl = $urandom_range(TMO, 0);
            ll = $urandom_range(TMO, 0);
            we = ($urandom_range(4) == 0);
            le = ($urandom_range(4) == 0);
            hd = (n != 39) && ($urandom_range(3) == 0);
            do_miss(ev, $urandom, rand_line(), $urandom, 2'($urandom),
                    wl, we, ll, le, 30, hd);
        end

        @(negedge clock);
        miss_valid = 1'b0;
        idle_bus();
        chk("final_ready", miss_ready, 1);
        chk("final_no_fill", fill_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
